pbit_sweep_scheduler: RTL and testbench

Sequencer and annealing controller for the p-bit network datapath. Steps through the graph-colouring update groups with a programmable settle time per group. Counts completed sweeps and ramps the interconnection strength I_0 (Q4.3) on a fixed schedule. Sits between the host/ILA control logic and the sparse-multiply/P_bit array, replacing the free-running group/clk_delay counter with a start/stop-controlled run.

---
 rtl/pbit_sched_pkg.sv | 23 ++
 rtl/beta_ramp.sv | 52 +++++
 rtl/pbit_sweep_scheduler.sv | 134 +++++++++++++
 tb/tb_pbit_sweep_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_sched_pkg.sv
// Shared types and constants for the p-bit sweep scheduler.
// I_0 is unsigned Q4.3 throughout.
package pbit_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } state_e;

  localparam int unsigned I0_W = 8;
  localparam logic [I0_W-1:0] ONE = 8'd8;

  // Sum is formed one bit wider so a carry out still saturates to lim.
  function automatic logic [I0_W-1:0] sat_add(input logic [I0_W-1:0] a,
                                              input logic [I0_W-1:0] b,
                                              input logic [I0_W-1:0] lim);
    logic [I0_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[I0_W-1:0];
  endfunction

endpackage

// File: rtl/beta_ramp.sv
// Annealing ramp: counts completed sweeps and steps I_0 towards BETA_MAX
// every SWEEPS_PER_STEP sweeps while enabled.
module beta_ramp
  import pbit_sched_pkg::*;
#(
  parameter logic [I0_W-1:0] BETA_START      = ONE,
  parameter logic [I0_W-1:0] BETA_STEP       = 8'd2,
  parameter logic [I0_W-1:0] BETA_MAX        = 8'd64,
  parameter int unsigned     SWEEPS_PER_STEP = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            sweep_tick,
  input  logic            enable,
  output logic [I0_W-1:0] I_0
);

  localparam int unsigned StepW = $clog2(SWEEPS_PER_STEP + 1);

  logic [StepW-1:0] step_q, step_d;
  logic [I0_W-1:0]  i0_q, i0_d;

  always_comb begin
    step_d = step_q;
    i0_d   = i0_q;
    if (clear) begin
      step_d = '0;
      i0_d   = BETA_START;
    end else if (enable && sweep_tick) begin
      if (step_q == StepW'(SWEEPS_PER_STEP - 1)) begin
        step_d = '0;
        i0_d   = sat_add(i0_q, BETA_STEP, BETA_MAX);
      end else begin
        step_d = step_q + StepW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= '0;
      i0_q   <= BETA_START;
    end else begin
      step_q <= step_d;
      i0_q   <= i0_d;
    end
  end

  assign I_0 = i0_q;

endmodule

// File: rtl/pbit_sweep_scheduler.sv
// Start/stop controlled sweep sequencer: walks colour groups with a fixed
// settle time, counts sweeps and drives the annealed I_0.
module pbit_sweep_scheduler
  import pbit_sched_pkg::*;
#(
  parameter int unsigned     NUM_GROUPS      = 4,
  parameter int unsigned     SETTLE_CYCLES   = 4,
  parameter int unsigned     SWEEP_W         = 16,
  parameter logic [I0_W-1:0] BETA_START      = ONE,
  parameter logic [I0_W-1:0] BETA_STEP       = 8'd2,
  parameter logic [I0_W-1:0] BETA_MAX        = 8'd64,
  parameter int unsigned     SWEEPS_PER_STEP = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             stop,
  input  logic [SWEEP_W-1:0]               num_sweeps,
  input  logic                             anneal_EN,
  output logic [$clog2(NUM_GROUPS)-1:0]    group_EN,
  output logic                             group_valid,
  output logic [$clog2(SETTLE_CYCLES)-1:0] phase,
  output logic [I0_W-1:0]                  I_0,
  output logic [SWEEP_W-1:0]               sweep_cnt,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned GrpW = $clog2(NUM_GROUPS);
  localparam int unsigned PhW  = $clog2(SETTLE_CYCLES);

  state_e             state_q, state_d;
  logic [GrpW-1:0]    group_q, group_d;
  logic [PhW-1:0]     phase_q, phase_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [SWEEP_W-1:0] num_q, num_d;
  logic               anneal_q, anneal_d;
  logic               stop_pend_q, stop_pend_d;

  logic phase_last, group_last, count_end, sweep_tick, ramp_clear;

  assign phase_last = (phase_q == PhW'(SETTLE_CYCLES - 1));
  assign group_last = (group_q == GrpW'(NUM_GROUPS - 1));
  // num_q is nonzero here, so the subtraction cannot underflow.
  assign count_end  = (num_q != '0) && (sweep_q == num_q - SWEEP_W'(1));
  assign sweep_tick = (state_q == StRun) && phase_last && group_last;
  assign ramp_clear = (state_q == StIdle) && start;

  always_comb begin
    state_d     = state_q;
    group_d     = group_q;
    phase_d     = phase_q;
    sweep_d     = sweep_q;
    num_d       = num_q;
    anneal_d    = anneal_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start) begin
          state_d  = StRun;
          num_d    = num_sweeps;
          anneal_d = anneal_EN;
          sweep_d  = '0;
          group_d  = '0;
          phase_d  = '0;
        end
      end
      StRun: begin
        stop_pend_d = stop_pend_q | stop;
        if (phase_last) begin
          phase_d = '0;
          if (group_last) begin
            group_d = '0;
            sweep_d = (&sweep_q) ? sweep_q : sweep_q + SWEEP_W'(1);
            // A stop seen in the sweep's final cycle still ends this sweep.
            if (count_end || stop_pend_q || stop) state_d = StFinish;
          end else begin
            group_d = group_q + GrpW'(1);
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StFinish: begin
        state_d     = StIdle;
        stop_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      group_q     <= '0;
      phase_q     <= '0;
      sweep_q     <= '0;
      num_q       <= '0;
      anneal_q    <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      group_q     <= group_d;
      phase_q     <= phase_d;
      sweep_q     <= sweep_d;
      num_q       <= num_d;
      anneal_q    <= anneal_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  beta_ramp #(
    .BETA_START     (BETA_START),
    .BETA_STEP      (BETA_STEP),
    .BETA_MAX       (BETA_MAX),
    .SWEEPS_PER_STEP(SWEEPS_PER_STEP)
  ) u_beta_ramp (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (ramp_clear),
    .sweep_tick(sweep_tick),
    .enable    (anneal_q),
    .I_0       (I_0)
  );

  assign group_EN    = group_q;
  assign phase       = phase_q;
  assign sweep_cnt   = sweep_q;
  assign group_valid = (state_q == StRun);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StFinish);

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Bench for pbit_sweep_scheduler: table of runs checked cycle by cycle, a
// done-pulse scoreboard, plus reset-mid-run and I_0 saturation sequences.
module tb_pbit_sweep_scheduler;

  typedef struct {
    logic [15:0] num;
    logic        anneal;
    logic        stop_with_start;
    int          stop_cycle;
    int          restart_cycle;
    int          exp_sweeps;
  } vec_t;

  typedef struct {
    logic [15:0] sweeps;
    logic [7:0]  i0;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, stop, anneal_EN;
  logic [15:0] num_sweeps;
  logic [1:0]  group_EN, phase;
  logic        group_valid, busy, done;
  logic [7:0]  I_0;
  logic [15:0] sweep_cnt;

  logic        start2, stop2, an2;
  logic [15:0] num2;
  logic [1:0]  g2, ph2;
  logic        v2, busy2, done2;
  logic [7:0]  i02;
  logic [15:0] sc2;

  int        n_vec = 0;
  int        n_bad = 0;
  done_exp_t done_q[$];
  done_exp_t mon_e;
  vec_t      vecs[7];

  always #5 clk = ~clk;

  pbit_sweep_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .num_sweeps (num_sweeps),
    .anneal_EN  (anneal_EN),
    .group_EN   (group_EN),
    .group_valid(group_valid),
    .phase      (phase),
    .I_0        (I_0),
    .sweep_cnt  (sweep_cnt),
    .busy       (busy),
    .done       (done)
  );

  pbit_sweep_scheduler #(
    .BETA_STEP      (8'd40),
    .SWEEPS_PER_STEP(1)
  ) dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start2),
    .stop       (stop2),
    .num_sweeps (num2),
    .anneal_EN  (an2),
    .group_EN   (g2),
    .group_valid(v2),
    .phase      (ph2),
    .I_0        (i02),
    .sweep_cnt  (sc2),
    .busy       (busy2),
    .done       (done2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic v, input logic b, input logic d,
                                       input logic [1:0] g, input logic [1:0] ph,
                                       input logic [7:0] i0, input logic [15:0] sc);
    return {33'b0, v, b, d, g, ph, i0, sc};
  endfunction

  function automatic logic [63:0] pack_act();
    return pack(group_valid, busy, done, group_EN, phase, I_0, sweep_cnt);
  endfunction

  // Reference I_0 after s completed sweeps.
  function automatic int exp_i0(input int s, input logic an, input int st, input int step,
                                input int mx, input int sps);
    int v;
    v = st;
    if (an) begin
      for (int i = 1; i <= s; i++) begin
        if (i % sps == 0) begin
          v += step;
          if (v > mx) v = mx;
        end
      end
    end
    return v;
  endfunction

  // Scoreboard: every done pulse must match an outstanding run.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done_unexpected: done=1 with no run outstanding, expected 0");
      end else begin
        mon_e = done_q.pop_front();
        check("done_sweep_cnt", 64'(sweep_cnt), 64'(mon_e.sweeps));
        check("done_I_0", 64'(I_0), 64'(mon_e.i0));
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int i0f;
    int s;
    i0f = exp_i0(v.exp_sweeps, v.anneal, 8, 2, 64, 16);
    @(negedge clk);
    num_sweeps = v.num;
    anneal_EN  = v.anneal;
    start      = 1'b1;
    stop       = v.stop_with_start;
    done_q.push_back('{sweeps: 16'(v.exp_sweeps), i0: 8'(i0f)});
    @(negedge clk);
    for (int k = 0; k < v.exp_sweeps * 16; k++) begin
      s = k / 16;
      check({tag, "/run"}, pack_act(),
            pack(1'b1, 1'b1, 1'b0, 2'((k / 4) % 4), 2'(k % 4),
                 8'(exp_i0(s, v.anneal, 8, 2, 64, 16)), 16'(s)));
      start = (k == v.restart_cycle);
      stop  = (k == v.stop_cycle);
      if (k == v.restart_cycle) begin
        num_sweeps = 16'd9;
        anneal_EN  = ~v.anneal;
      end
      @(negedge clk);
    end
    start = 1'b0;
    stop  = 1'b0;
    check({tag, "/finish"}, pack_act(),
          pack(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 8'(i0f), 16'(v.exp_sweeps)));
    @(negedge clk);
    check({tag, "/idle"}, pack_act(),
          pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'(i0f), 16'(v.exp_sweeps)));
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    anneal_EN  = 1'b0;
    num_sweeps = '0;
    start2     = 1'b0;
    stop2      = 1'b0;
    an2        = 1'b0;
    num2       = '0;

    vecs[0] = '{num: 16'd2,  anneal: 1'b0, stop_with_start: 1'b0, stop_cycle: -1,
                restart_cycle: -1, exp_sweeps: 2};
    vecs[1] = '{num: 16'd2,  anneal: 1'b1, stop_with_start: 1'b1, stop_cycle: -1,
                restart_cycle: -1, exp_sweeps: 2};
    vecs[2] = '{num: 16'd2,  anneal: 1'b0, stop_with_start: 1'b0, stop_cycle: -1,
                restart_cycle: 5, exp_sweeps: 2};
    vecs[3] = '{num: 16'd10, anneal: 1'b0, stop_with_start: 1'b0, stop_cycle: 47,
                restart_cycle: -1, exp_sweeps: 3};
    vecs[4] = '{num: 16'd17, anneal: 1'b1, stop_with_start: 1'b0, stop_cycle: -1,
                restart_cycle: -1, exp_sweeps: 17};
    vecs[5] = '{num: 16'd3,  anneal: 1'b1, stop_with_start: 1'b0, stop_cycle: 0,
                restart_cycle: -1, exp_sweeps: 1};
    vecs[6] = '{num: 16'd0,  anneal: 1'b1, stop_with_start: 1'b0, stop_cycle: 64 * 16 + 5,
                restart_cycle: -1, exp_sweeps: 65};

    repeat (2) @(negedge clk);
    check("reset_values", pack_act(), pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd8, 16'd0));
    check("reset_values_sat", pack(v2, busy2, done2, g2, ph2, i02, sc2),
          pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd8, 16'd0));
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during group 2 of the second sweep: no done, outputs clear at once.
    @(negedge clk);
    num_sweeps = 16'd5;
    anneal_EN  = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_run_group", 64'(group_EN), 64'd2);
    check("mid_run_sweep", 64'(sweep_cnt), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_run", pack_act(), pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd8, 16'd0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_vec(vecs[0], "after_reset");

    // Saturating ramp: step 40 every sweep.
    @(negedge clk);
    num2   = 16'd4;
    an2    = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      repeat (16) @(negedge clk);
      check($sformatf("sat_I_0_s%0d", s), 64'(i02), 64'(exp_i0(s, 1'b1, 8, 40, 64, 1)));
      check($sformatf("sat_done_s%0d", s), 64'(done2), 64'(s == 4));
    end
    check("sat_finish", pack(v2, busy2, done2, g2, ph2, i02, sc2),
          pack(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 8'd64, 16'd4));
    @(negedge clk);
    check("sat_idle", 64'(busy2), 64'd0);

    repeat (3) @(negedge clk);
    check("done_outstanding", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
